fnd_scan_controller: RTL and testbench

Parametrised multiplexed FND (7-segment) scan controller that replaces the free-running 3-bit digit counter. A prescaler sets the per-digit dwell time, and a wrapping digit index selects one digit at a time. Per-slot blanking suppresses ghosting, the display value is snapshotted once per frame to prevent tearing, and optional leading-zero suppression and per-digit decimal points are provided. It sits between the clock/time counters and the board's common-anode FND pins.

---
 rtl/fnd_if.sv | 31 +++
 rtl/fnd_scan_controller.sv | 149 ++++++++++++++
 tb/tb_fnd_scan_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fnd_if.sv
`default_nettype none
// ============================================================================
// Module   : fnd_if
// Brief    : Control and display bus between the FND scan controller and its
//            user: scan control/data in, digit enables and segments out.
// Revision : 1.0
// ============================================================================
interface fnd_if #(
    parameter int N_DIGITS = 4,
    parameter int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
);
    logic                  i_enable;
    logic [4*N_DIGITS-1:0] i_digits;
    logic [N_DIGITS-1:0]   i_dp;
    logic                  i_lz_suppress;
    logic [N_DIGITS-1:0]   o_digit_sel;
    logic [7:0]            o_seg;
    logic [IDX_W-1:0]      o_scan_idx;
    logic                  o_frame_tick;

    modport master (
        output i_enable, i_digits, i_dp, i_lz_suppress,
        input  o_digit_sel, o_seg, o_scan_idx, o_frame_tick
    );

    modport slave (
        input  i_enable, i_digits, i_dp, i_lz_suppress,
        output o_digit_sel, o_seg, o_scan_idx, o_frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_controller
// Brief    : Multiplexed common-anode 7-segment scanner with per-slot blanking,
//            per-frame snapshot, leading-zero suppression and decimal points.
// Revision : 1.0
// ============================================================================
module fnd_scan_controller #(
    parameter int N_DIGITS     = 4,
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic i_clk,
    input  logic i_reset,
    fnd_if.slave fnd
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]       C_PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]       C_BLANK      = PW'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]    C_IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] C_ONE_HOT0   = N_DIGITS'(1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  primed_q, primed_d;
    logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                  snap_lz_q, snap_lz_d;
    logic [N_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic                  tick_q, tick_d;

    logic                  w_slot_end;
    logic                  w_frame_end;
    logic [3:0]            w_nibbles [N_DIGITS];
    logic [N_DIGITS-1:0]   w_lz_mask;
    logic [6:0]            w_seg_bits;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] s;
        s = 8'hFF;
        case (nib)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            4'hF: s = 8'h8E;
            default: s = 8'hFF;
        endcase
        return s[6:0];
    endfunction

    generate
        for (genvar k = 0; k < N_DIGITS; k++) begin : g_nib
            assign w_nibbles[k] = snap_digits_q[4*k +: 4];
            // A digit is a leading zero when it and every digit above it are zero.
            if (k == 0) begin : g_lz_units
                assign w_lz_mask[k] = 1'b0;
            end else begin : g_lz_upper
                assign w_lz_mask[k] = (snap_digits_q[4*N_DIGITS-1:4*k] == '0);
            end
        end
    endgenerate

    assign w_slot_end  = (presc_q == C_PRESC_LAST);
    assign w_frame_end = w_slot_end && (idx_q == C_IDX_LAST);
    assign w_seg_bits  = (snap_lz_q && w_lz_mask[idx_q]) ? 7'h7F : hex_to_seg(w_nibbles[idx_q]);

    always_comb begin
        presc_d       = presc_q;
        idx_d         = idx_q;
        primed_d      = primed_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_lz_d     = snap_lz_q;
        if (fnd.i_enable) begin
            if (w_slot_end) begin
                presc_d = '0;
                idx_d   = (idx_q == C_IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
            // Snapshot only at frame boundaries so a frame never mixes two values.
            if (!primed_q || w_frame_end) begin
                snap_digits_d = fnd.i_digits;
                snap_dp_d     = fnd.i_dp;
                snap_lz_d     = fnd.i_lz_suppress;
            end
            primed_d = 1'b1;
        end
    end

    always_comb begin
        sel_d      = '1;
        seg_d      = 8'hFF;
        scan_idx_d = idx_q;
        tick_d     = fnd.i_enable && w_frame_end;
        if (fnd.i_enable && (presc_q >= C_BLANK)) begin
            sel_d = ~(C_ONE_HOT0 << idx_q);
            seg_d = {~snap_dp_q[idx_q], w_seg_bits};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            primed_q      <= 1'b0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
            sel_q         <= '1;
            seg_q         <= 8'hFF;
            scan_idx_q    <= '0;
            tick_q        <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            primed_q      <= primed_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
            scan_idx_q    <= scan_idx_d;
            tick_q        <= tick_d;
        end
    end

    assign fnd.o_digit_sel  = sel_q;
    assign fnd.o_seg        = seg_q;
    assign fnd.o_scan_idx   = scan_idx_q;
    assign fnd.o_frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_scan_controller
// Brief    : Directed and random stimulus against a time-based display model.
// Revision : 1.0
// ============================================================================
module tb_fnd_scan_controller;
    localparam int ND = 4;
    localparam int CD = 4;
    localparam int BL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fnd_if #(.N_DIGITS(ND)) fnd ();

    fnd_scan_controller #(
        .N_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BL)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .fnd    (fnd)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: the scan position is a pure function of enabled cycles since reset.
    int          en_cycles = 0;
    bit          primed    = 0;
    logic [15:0] snap_d    = '0;
    logic [3:0]  snap_dp   = '0;
    logic        snap_lz   = 1'b0;
    logic [7:0]  HEX_TBL [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int m_presc();
        return en_cycles % CD;
    endfunction

    function automatic int m_idx();
        return (en_cycles / CD) % ND;
    endfunction

    function automatic logic [7:0] exp_seg(input int idx);
        int         top;
        logic [3:0] nib;
        logic       blank;
        top = 0;
        for (int k = 0; k < ND; k++)
            if (((snap_d >> (4*k)) & 16'hF) != 16'h0) top = k;
        nib   = 4'((snap_d >> (4*idx)) & 16'hF);
        blank = snap_lz && (idx > top);
        return {~snap_dp[idx], blank ? 7'h7F : HEX_TBL[nib][6:0]};
    endfunction

    task automatic cycle();
        logic [3:0] e_sel;
        logic [7:0] e_seg;
        logic [1:0] e_idx;
        logic       e_tick;
        int         presc, idx;
        presc  = m_presc();
        idx    = m_idx();
        e_sel  = 4'hF;
        e_seg  = 8'hFF;
        e_tick = 1'b0;
        e_idx  = 2'(idx);
        if (rst) begin
            e_idx     = 2'd0;
            en_cycles = 0;
            primed    = 0;
            snap_d    = '0;
            snap_dp   = '0;
            snap_lz   = 1'b0;
        end else if (fnd.i_enable) begin
            if (presc >= BL) begin
                e_sel = ~(4'b0001 << idx);
                e_seg = exp_seg(idx);
            end
            e_tick = ((en_cycles % (CD*ND)) == CD*ND - 1);
            if (!primed || e_tick) begin
                snap_d  = fnd.i_digits;
                snap_dp = fnd.i_dp;
                snap_lz = fnd.i_lz_suppress;
            end
            primed = 1;
            en_cycles++;
        end
        @(posedge clk);
        #1;
        chk("digit_sel",  32'(fnd.o_digit_sel),  32'(e_sel));
        chk("seg",        32'(fnd.o_seg),        32'(e_seg));
        chk("scan_idx",   32'(fnd.o_scan_idx),   32'(e_idx));
        chk("frame_tick", 32'(fnd.o_frame_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input string tag, input int idx, input int presc);
        int  guard;
        bit  hit;
        guard = 0;
        hit   = (m_idx() == idx) && (m_presc() == presc);
        while (!hit && guard < 64) begin
            cycle();
            guard++;
            hit = (m_idx() == idx) && (m_presc() == presc);
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        HEX_TBL = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        fnd.i_enable      = 1'b1;
        fnd.i_digits      = 16'h1234;
        fnd.i_dp          = 4'h0;
        fnd.i_lz_suppress = 1'b0;

        // Reset overrides enable; outputs dark.
        rst = 1'b1;
        run(2);
        chk("reset_seg_const", 32'(fnd.o_seg), 32'h0000_00FF);
        rst = 1'b0;

        // Scan order and timing.
        run(40);

        // Leading-zero suppression.
        fnd.i_digits      = 16'h0070;
        fnd.i_lz_suppress = 1'b1;
        run(36);
        fnd.i_digits = 16'h0000;
        run(36);

        // Anti-tearing: change mid-frame.
        fnd.i_digits      = 16'h1234;
        fnd.i_lz_suppress = 1'b0;
        run(20);
        run_to("reach_idx1", 1, 1);
        fnd.i_digits = 16'h5678;
        run(36);

        // Enable freeze at idx 2, prescaler 2.
        run_to("reach_idx2", 2, 2);
        fnd.i_enable = 1'b0;
        run(10);
        fnd.i_enable = 1'b1;
        run(20);

        // Reset mid-scan.
        run_to("reach_idx3", 3, 2);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        fnd.i_digits = 16'h9087;
        run(36);

        // Decimal point and hex letters.
        fnd.i_digits = 16'hABCD;
        fnd.i_dp     = 4'b0100;
        run(36);

        // Randomized traffic.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 7) == 0)  fnd.i_digits = 16'($urandom);
            if ($urandom_range(0, 15) == 0) fnd.i_digits = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0)  fnd.i_dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0) fnd.i_lz_suppress = 1'($urandom);
            fnd.i_enable = ($urandom_range(0, 9) != 0);
            rst          = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
